// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants and types for the PWM generator
//
// Purpose: CTRL register bit positions, counter width and FSM state type
//          used by pwm_gen and its sub-modules.
// Ports:   none (package).

package pwm_pkg;

    // CTRL register layout
    localparam int EN_BIT  = 0;
    localparam int INV_BIT = 1;
    localparam int DIV_LSB = 4;
    localparam int DIV_MSB = 7;

    // Period counter
    localparam int                    PWM_CNT_W = 8;
    localparam logic [PWM_CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } pwm_state_t;

endpackage

// File: rtl/pwm_prescaler.sv
// rtl/pwm_prescaler.sv - divide-by-(div+1) tick generator for the PWM period counter
//
// Purpose: emits a one-cycle tick every div+1 clocks while run is high.
// Ports:
//   clk     - system clock
//   reset_n - asynchronous active-low reset
//   run     - counting enabled (FSM in RUN or STOP)
//   div     - divide value; tick period is div+1 clocks
//   tick    - one-cycle pulse that advances the period counter

module pwm_prescaler #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] count_d;

    assign tick = run && (count_q == '0);

    // Reloading while parked means the first tick after run rises lands
    // exactly div cycles later. A DIV change while running is picked up
    // only at the next reload, so the interval in progress is not cut short.
    always_comb begin
        count_d = count_q;
        if (!run || tick) begin
            count_d = div;
        end else begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - register-mapped 8-bit PWM generator with double-buffered duty
//
// Purpose: CTRL/DUTY registers, enable FSM, 256-step period counter, duty
//          compare and registered read mux for the register wrapper.
// Ports:
//   clk, reset_n             - clock, asynchronous active-low reset
//   wr_en_ctrl, wr_en_duty   - 1-cycle write strobes (data_in -> CTRL / DUTY_SHADOW)
//   rd_en_ctrl, rd_en_duty   - 1-cycle read strobes (register -> data_out)
//   data_in  [7:0]           - write data
//   data_out [7:0]           - registered read data, holds between reads
//   pwm_out                  - registered PWM output
//   period_tick              - 1-cycle pulse, counter wrap delayed one cycle

module pwm_gen
    import pwm_pkg::*;
#(
    parameter int DIV_W = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr_en_ctrl,
    input  logic       wr_en_duty,
    input  logic       rd_en_ctrl,
    input  logic       rd_en_duty,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       pwm_out,
    output logic       period_tick
);

    // Registers
    logic [7:0]           ctrl_q,        ctrl_d;
    logic [7:0]           duty_shadow_q, duty_shadow_d;
    logic [7:0]           duty_active_q, duty_active_d;
    logic [PWM_CNT_W-1:0] cnt_q,         cnt_d;
    pwm_state_t           state_q,       state_d;
    logic [7:0]           data_out_q,    data_out_d;
    logic                 pwm_q,         pwm_d;
    logic                 period_tick_q, period_tick_d;

    // Internal
    logic             en_next;
    logic             inv;
    logic [DIV_W-1:0] div_next;
    logic             run;
    logic             tick;
    logic             wrap;
    logic             raw;

    // Register writes
    always_comb begin
        ctrl_d        = wr_en_ctrl ? data_in : ctrl_q;
        duty_shadow_d = wr_en_duty ? data_in : duty_shadow_q;
    end

    // The FSM and the parked prescaler look at the value CTRL is about to
    // take, so an EN write moves the FSM in the same edge that stores it.
    assign en_next  = ctrl_d[EN_BIT];
    assign div_next = ctrl_d[DIV_MSB:DIV_LSB];
    assign inv      = ctrl_q[INV_BIT];
    assign run      = (state_q != IDLE);

    pwm_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (run),
        .div     (div_next),
        .tick    (tick)
    );

    assign wrap = tick && (cnt_q == CNT_MAX);
    assign raw  = (cnt_q < duty_active_q);

    // FSM next state. In STOP a returning EN wins over a coincident wrap so
    // the counter keeps running without a gap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (en_next) state_d = RUN;
            end
            RUN: begin
                if (!en_next) state_d = STOP;
            end
            STOP: begin
                if (en_next) begin
                    state_d = RUN;
                end else if (wrap) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Period counter, duty buffering and output stage
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE || state_d == IDLE) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + 1'b1;
        end

        // Shadow is only copied at a period boundary, or continuously while
        // parked so the first period after enable uses the newest value.
        duty_active_d = duty_active_q;
        if (state_q == IDLE || wrap) begin
            duty_active_d = duty_shadow_q;
        end

        pwm_d         = run ? (raw ^ inv) : inv;
        period_tick_d = wrap;
    end

    // Read mux: CTRL has priority; reads see pre-write register contents.
    always_comb begin
        data_out_d = data_out_q;
        if (rd_en_ctrl) begin
            data_out_d = ctrl_q;
        end else if (rd_en_duty) begin
            data_out_d = duty_shadow_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q        <= '0;
            duty_shadow_q <= '0;
            duty_active_q <= '0;
            cnt_q         <= '0;
            state_q       <= IDLE;
            data_out_q    <= '0;
            pwm_q         <= 1'b0;
            period_tick_q <= 1'b0;
        end else begin
            ctrl_q        <= ctrl_d;
            duty_shadow_q <= duty_shadow_d;
            duty_active_q <= duty_active_d;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            data_out_q    <= data_out_d;
            pwm_q         <= pwm_d;
            period_tick_q <= period_tick_d;
        end
    end

    assign data_out    = data_out_q;
    assign pwm_out     = pwm_q;
    assign period_tick = period_tick_q;

endmodule

// File: tb/tb_pwm_gen.sv
// tb/tb_pwm_gen.sv - directed self-checking bench for pwm_gen

module tb_pwm_gen;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_en_ctrl = 1'b0;
    logic       wr_en_duty = 1'b0;
    logic       rd_en_ctrl = 1'b0;
    logic       rd_en_duty = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       pwm_out;
    logic       period_tick;

    int n_checks = 0;
    int n_pass   = 0;

    pwm_gen #(.DIV_W(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en_ctrl  (wr_en_ctrl),
        .wr_en_duty  (wr_en_duty),
        .rd_en_ctrl  (rd_en_ctrl),
        .rd_en_duty  (rd_en_duty),
        .data_in     (data_in),
        .data_out    (data_out),
        .pwm_out     (pwm_out),
        .period_tick (period_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // All tasks start and end at a falling edge.
    task automatic wr_ctrl(input logic [7:0] v);
        wr_en_ctrl = 1'b1; data_in = v;
        @(negedge clk);
        wr_en_ctrl = 1'b0;
    endtask

    task automatic wr_duty(input logic [7:0] v);
        wr_en_duty = 1'b1; data_in = v;
        @(negedge clk);
        wr_en_duty = 1'b0;
    endtask

    task automatic rd_ctrl(output logic [7:0] v);
        rd_en_ctrl = 1'b1;
        @(negedge clk);
        rd_en_ctrl = 1'b0;
        v = data_out;
    endtask

    task automatic rd_duty(output logic [7:0] v);
        rd_en_duty = 1'b1;
        @(negedge clk);
        rd_en_duty = 1'b0;
        v = data_out;
    endtask

    // Waits for a period_tick, then counts high cycles and length up to the
    // next one. Returns positioned on that next period_tick cycle.
    task automatic measure(output int highs, output int len);
        int guard;
        guard = 0; highs = 0; len = 0;
        while (!period_tick && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        do begin
            highs += int'(pwm_out);
            len++;
            @(negedge clk);
        end while (!period_tick && len < 3000);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] rv;
        int highs, len, first_pt, cycles, ticks;

        // Reset
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_ptick", period_tick, 0);
        chk("rst_dout", data_out, 8'h00);
        reset_n = 1'b1;
        @(negedge clk);
        rd_ctrl(rv); chk("rst_ctrl_rd", rv, 8'h00);
        rd_duty(rv); chk("rst_duty_rd", rv, 8'h00);

        // DUTY=0x40, enable at DIV=0
        wr_duty(8'h40);
        wr_ctrl(8'h01);
        highs = 0; first_pt = 0;
        for (int i = 1; i <= 257; i++) begin
            if (i == 1)  chk("en_pwm_n1", pwm_out, 0);
            if (i == 2)  chk("en_pwm_n2", pwm_out, 1);
            if (i == 65) chk("d40_last_high", pwm_out, 1);
            if (i == 66) chk("d40_first_low", pwm_out, 0);
            highs += int'(pwm_out);
            if (period_tick && first_pt == 0) first_pt = i;
            if (i < 257) @(negedge clk);
        end
        chk("d40_highs", highs, 64);
        chk("first_ptick_at", first_pt, 257);

        // Duty change at cnt=10: current period unaffected, next one uses it
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            highs += int'(pwm_out);
            if (i == 10) begin wr_en_duty = 1'b1; data_in = 8'hC0; end
            if (i == 11) begin wr_en_duty = 1'b0; rd_en_duty = 1'b1; end
            if (i == 12) begin rd_en_duty = 1'b0; chk("duty_rb_immediate", data_out, 8'hC0); end
            @(negedge clk);
        end
        chk("dchg_ptick", period_tick, 1);
        chk("dchg_cur_highs", highs, 64);
        measure(highs, len);
        chk("dchg_next_highs", highs, 192);
        chk("dchg_next_len", len, 256);

        // Disable at cnt=100: period completes, then output parks
        repeat (100) @(negedge clk);
        wr_en_ctrl = 1'b1; data_in = 8'h00;
        first_pt = 0;
        for (int j = 1; j <= 400 && first_pt == 0; j++) begin
            @(negedge clk);
            wr_en_ctrl = 1'b0;
            if (j == 51) chk("stop_still_running", pwm_out, 1);
            if (period_tick) first_pt = j;
        end
        chk("stop_ptick_at", first_pt, 156);
        highs = 0; ticks = 0;
        for (int j = 0; j < 300; j++) begin
            @(negedge clk);
            highs += int'(pwm_out);
            ticks += int'(period_tick);
        end
        chk("idle_pwm_highs", highs, 0);
        chk("idle_ptick_count", ticks, 0);

        // Re-enable; disable at cnt=100 and re-enable at cnt=200 (no restart)
        wr_ctrl(8'h01);
        measure(highs, len);
        chk("reen_highs", highs, 192);
        chk("reen_len", len, 256);
        repeat (100) @(negedge clk);
        wr_ctrl(8'h00);
        repeat (99) @(negedge clk);
        wr_ctrl(8'h01);
        cycles = 0;
        while (!period_tick && cycles < 400) begin
            @(negedge clk);
            cycles++;
        end
        chk("resume_ptick_after", cycles, 55);
        measure(highs, len);
        chk("resume_highs", highs, 192);
        chk("resume_len", len, 256);

        // INV + DIV=3, DUTY=0x80
        wr_duty(8'h80);
        wr_ctrl(8'h33);
        measure(highs, len);
        chk("div3_highs", highs, 512);
        chk("div3_len", len, 1024);
        for (int k = 0; k <= 600; k++) begin
            if (k == 2)   chk("div3_pwm_k2", pwm_out, 0);
            if (k == 512) chk("div3_pwm_k512", pwm_out, 0);
            if (k == 513) chk("div3_pwm_k513", pwm_out, 1);
            if (k == 600) chk("div3_pwm_k600", pwm_out, 1);
            if (k < 600) @(negedge clk);
        end

        // Read port priority and read-during-write
        wr_ctrl(8'h21);
        rd_en_ctrl = 1'b1; rd_en_duty = 1'b1;
        @(negedge clk);
        rd_en_ctrl = 1'b0; rd_en_duty = 1'b0;
        chk("rd_both_ctrl_wins", data_out, 8'h21);
        rd_en_ctrl = 1'b1; wr_en_ctrl = 1'b1; data_in = 8'h55;
        @(negedge clk);
        rd_en_ctrl = 1'b0; wr_en_ctrl = 1'b0;
        chk("rd_wr_same_old", data_out, 8'h21);
        rd_ctrl(rv); chk("rd_ctrl_new_rsvd", rv, 8'h55);
        rd_duty(rv); chk("rd_duty", rv, 8'h80);
        repeat (3) @(negedge clk);
        chk("dout_holds", data_out, 8'h80);

        // Asynchronous reset mid-period with INV set
        wr_ctrl(8'h03);
        repeat (20) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("arst_pwm", pwm_out, 0);
        chk("arst_ptick", period_tick, 0);
        chk("arst_dout", data_out, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        rd_ctrl(rv); chk("arst_ctrl_rd", rv, 8'h00);
        rd_duty(rv); chk("arst_duty_rd", rv, 8'h00);
        repeat (5) @(negedge clk);
        chk("arst_pwm_after", pwm_out, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
